// File: rtl/demux1to2_buf_pkg.sv
// rtl/demux1to2_buf_pkg.sv - shared datapath constants and types for the buffered 1-to-2 demux
package demux1to2_buf_pkg;

    localparam int DATA_W      = 32;
    localparam int DEMUX_WIDTH = DATA_W;
    localparam int DEMUX_DEPTH = 2;

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    typedef enum logic {
        DEST_OUT1 = 1'b0,
        DEST_OUT2 = 1'b1
    } dest_e;

    // Occupancy after one cycle; push and pop together leave it unchanged.
    function automatic logic [1:0] next_count(
        input logic [1:0] cnt,
        input logic       push,
        input logic       pop
    );
        logic [1:0] nxt;
        nxt = cnt;
        case ({push, pop})
            2'b10:   nxt = cnt + 2'd1;
            2'b01:   nxt = cnt - 2'd1;
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/demux1to2_buf_fifo2.sv
// rtl/demux1to2_buf_fifo2.sv - two-entry FIFO with push/pop/flush and full/empty flags
module demux1to2_buf_fifo2
    import demux1to2_buf_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int DEPTH = DEMUX_DEPTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    logic             w_push;
    logic             w_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign w_push = i_push & (r_count != CNT_FULL);
    assign w_pop  = i_pop  & (r_count != CNT_EMPTY);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= CNT_EMPTY;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= CNT_EMPTY;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= next_count(r_count, w_push, w_pop);
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == CNT_EMPTY);

endmodule

// File: rtl/demux1to2_buf.sv
// rtl/demux1to2_buf.sv - 1-to-2 demux with a two-entry FIFO on each output
module demux1to2_buf
    import demux1to2_buf_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int DEPTH = DEMUX_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready
);

    dest_e w_dest;
    logic  w_full1;
    logic  w_full2;
    logic  w_empty1;
    logic  w_empty2;
    logic  w_accept;
    logic  w_push1;
    logic  w_push2;
    logic  w_pop1;
    logic  w_pop2;

    assign w_dest = dest_e'(sel);

    // Ready looks only at registered full, so a pop never frees a slot in the same cycle.
    assign in_ready = ~flush & ((w_dest == DEST_OUT2) ? ~w_full2 : ~w_full1);

    assign w_accept = in_valid & in_ready;
    assign w_push1  = w_accept & (w_dest == DEST_OUT1);
    assign w_push2  = w_accept & (w_dest == DEST_OUT2);

    assign out1_valid = ~w_empty1;
    assign out2_valid = ~w_empty2;
    assign w_pop1     = out1_valid & out1_ready;
    assign w_pop2     = out2_valid & out2_ready;

    demux1to2_buf_fifo2 #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .i_push  (w_push1),
        .i_data  (in_data),
        .i_pop   (w_pop1),
        .o_data  (out1_data),
        .o_full  (w_full1),
        .o_empty (w_empty1)
    );

    demux1to2_buf_fifo2 #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo2 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .i_push  (w_push2),
        .i_data  (in_data),
        .i_pop   (w_pop2),
        .o_data  (out2_data),
        .o_full  (w_full2),
        .o_empty (w_empty2)
    );

endmodule

// File: tb/tb_demux1to2_buf.sv
// tb/tb_demux1to2_buf.sv - directed and scoreboarded checks for demux1to2_buf
module tb_demux1to2_buf;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] in_data;
    logic        sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [31:0] out2_data;
    logic        out2_valid;
    logic        out2_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] q1[$];
    logic [31:0] q2[$];

    demux1to2_buf #(
        .WIDTH (32),
        .DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_data    (in_data),
        .sel        (sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int cyc;
        logic exp_ready;
        logic pop1;
        logic pop2;
        logic push;

        rst_n = 1'b0; flush = 1'b0; in_data = '0; sel = 1'b0; in_valid = 1'b0;
        out1_ready = 1'b0; out2_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_v1", out1_valid, 0);
        chk("rst_v2", out2_valid, 0);
        chk("rst_rdy", in_ready, 1);
        chk("rst_d1", out1_data, 0);
        chk("rst_d2", out2_data, 0);

        // routing
        out1_ready = 1'b1; out2_ready = 1'b1;
        in_valid = 1'b1; sel = 1'b0; in_data = 32'hAAAA0001;
        #1 chk("rt_rdy0", in_ready, 1);
        step();
        sel = 1'b1; in_data = 32'hBBBB0002;
        #1;
        chk("rt_v1", out1_valid, 1);
        chk("rt_d1", out1_data, 32'hAAAA0001);
        chk("rt_v2_none", out2_valid, 0);
        step();
        in_valid = 1'b0;
        #1;
        chk("rt_v2", out2_valid, 1);
        chk("rt_d2", out2_data, 32'hBBBB0002);
        chk("rt_v1_drained", out1_valid, 0);
        step();
        chk("rt_empty1", out1_valid, 0);
        chk("rt_empty2", out2_valid, 0);

        // backpressure and full
        out1_ready = 1'b0;
        in_valid = 1'b1; sel = 1'b0; in_data = 32'h1;
        #1 chk("bp_rdy1", in_ready, 1);
        step();
        in_data = 32'h2;
        #1 chk("bp_rdy2", in_ready, 1);
        chk("bp_head1", out1_data, 32'h1);
        step();
        in_data = 32'h3;
        #1 chk("bp_full", in_ready, 0);
        step();
        out1_ready = 1'b1;
        #1 chk("bp_full_pop", in_ready, 0);
        chk("bp_d1", out1_data, 32'h1);
        step();
        chk("bp_d2", out1_data, 32'h2);
        chk("bp_rdy3", in_ready, 1);
        step();
        chk("bp_d3", out1_data, 32'h3);
        chk("bp_v3", out1_valid, 1);
        in_valid = 1'b0;
        step();
        chk("bp_empty", out1_valid, 0);

        // independence
        out1_ready = 1'b0; out2_ready = 1'b0;
        in_valid = 1'b1; sel = 1'b0; in_data = 32'h10;
        step();
        in_data = 32'h11;
        step();
        in_data = 32'h12;
        #1 chk("ind_full1", in_ready, 0);
        sel = 1'b1; in_data = 32'h55;
        #1 chk("ind_rdy2", in_ready, 1);
        step();
        in_valid = 1'b0;
        #1;
        chk("ind_v2", out2_valid, 1);
        chk("ind_d2", out2_data, 32'h55);
        chk("ind_d1", out1_data, 32'h10);
        step();
        chk("ind_hold_d1", out1_data, 32'h10);
        chk("ind_hold_v1", out1_valid, 1);
        out1_ready = 1'b1;
        step();
        out1_ready = 1'b0;
        #1 chk("ind_d1b", out1_data, 32'h11);

        // flush with a concurrent offered word
        flush = 1'b1; in_valid = 1'b1; sel = 1'b0; in_data = 32'h99;
        #1 chk("fl_rdy", in_ready, 0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_v1", out1_valid, 0);
        chk("fl_v2", out2_valid, 0);
        chk("fl_rdy_after", in_ready, 1);
        step();
        chk("fl_v1_late", out1_valid, 0);

        // reset mid-stream
        in_valid = 1'b1; sel = 1'b1; in_data = 32'h77;
        step();
        in_valid = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("mr_v2", out2_valid, 0);
        chk("mr_d2", out2_data, 0);

        // random streaming against a scoreboard
        acc = 0;
        cyc = 0;
        while (acc < 100 && cyc < 3000) begin
            in_valid   = 1'($urandom_range(0, 1));
            sel        = 1'($urandom_range(0, 1));
            in_data    = $urandom;
            out1_ready = ($urandom_range(0, 3) != 0);
            out2_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = sel ? (q2.size() != 2) : (q1.size() != 2);
            chk("s_rdy", in_ready, exp_ready);
            chk("s_v1", out1_valid, q1.size() != 0);
            chk("s_v2", out2_valid, q2.size() != 0);
            if (q1.size() != 0) chk("s_d1", out1_data, q1[0]);
            if (q2.size() != 0) chk("s_d2", out2_data, q2[0]);
            pop1 = out1_ready && (q1.size() != 0);
            pop2 = out2_ready && (q2.size() != 0);
            push = in_valid && exp_ready;
            step();
            if (pop1) void'(q1.pop_front());
            if (pop2) void'(q2.pop_front());
            if (push) begin
                if (sel) q2.push_back(in_data);
                else     q1.push_back(in_data);
                acc++;
            end
            cyc++;
        end
        if (acc < 100) chk("s_timeout", acc, 100);

        in_valid = 1'b0; out1_ready = 1'b1; out2_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (q1.size() != 0) chk("dr_d1", out1_data, q1[0]);
            if (q2.size() != 0) chk("dr_d2", out2_data, q2[0]);
            pop1 = (q1.size() != 0);
            pop2 = (q2.size() != 0);
            step();
            if (pop1) void'(q1.pop_front());
            if (pop2) void'(q2.pop_front());
        end
        chk("dr_v1", out1_valid, 0);
        chk("dr_v2", out2_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
